// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle between the hiscore engine, the game CPU work-RAM port, the pause
// system, the work RAM and hs_ram_arbiter. The arbiter uses the slave modport.
interface hs_ram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          hs_access_req;
  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in;
  logic          hs_write_enable;
  logic [DW-1:0] hs_data_out;
  logic          hs_grant;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_we;
  logic [DW-1:0] cpu_dout;
  logic          cpu_pause_req;
  logic          cpu_paused;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          timeout_err;

  modport master (
    output hs_access_req, hs_address, hs_data_in, hs_write_enable,
    output cpu_addr, cpu_din, cpu_we, cpu_paused, ram_dout,
    input  hs_data_out, hs_grant, cpu_dout, cpu_pause_req,
    input  ram_addr, ram_din, ram_we, timeout_err
  );

  modport slave (
    input  hs_access_req, hs_address, hs_data_in, hs_write_enable,
    input  cpu_addr, cpu_din, cpu_we, cpu_paused, ram_dout,
    output hs_data_out, hs_grant, cpu_dout, cpu_pause_req,
    output ram_addr, ram_din, ram_we, timeout_err
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Shares the single-port game work RAM between the CPU and the hiscore engine.
// Define HS_ARB_TIMEOUT_EN to add the pause-ack timeout, BACKOFF state and timeout_err.
module hs_ram_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096,
  parameter int BACKOFF = 256
) (
  input logic             clk_49m,
  input logic             reset,
  hs_ram_arbiter_if.slave bus
);

  if (TIMEOUT < 1 || BACKOFF < 1) begin : g_bad_params
    $error("hs_ram_arbiter: TIMEOUT and BACKOFF must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PAUSE_REQ    = 3'd1,
    GRANT        = 3'd2,
    DRAIN        = 3'd3,
    BACKOFF_WAIT = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   grant_q;
  logic   pause_q;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CNT_MAX = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // One counter serves both the ack wait and the backoff; it restarts at 0 on every state entry.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef HS_ARB_TIMEOUT_EN
    cnt_d   = '0;
    terr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.hs_access_req) state_d = PAUSE_REQ;
      end
      PAUSE_REQ: begin
        if (!bus.hs_access_req) begin
          state_d = IDLE;
        end else if (bus.cpu_paused) begin
          state_d = GRANT;
`ifdef HS_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = BACKOFF_WAIT;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      // A falling cpu_paused is deliberately ignored here; only the hiscore side ends the grant.
      GRANT: begin
        if (!bus.hs_access_req) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
      end
      BACKOFF_WAIT: begin
`ifdef HS_ARB_TIMEOUT_EN
        if (cnt_q == CNT_W'(BACKOFF - 1)) state_d = IDLE;
        else                              cnt_d   = cnt_q + CNT_W'(1);
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      pause_q <= 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= (state_d == GRANT);
      pause_q <= (state_d == PAUSE_REQ) || (state_d == GRANT) || (state_d == DRAIN);
`ifdef HS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // DRAIN keeps the hiscore address on the RAM with writes off so the last write settles.
  logic          hs_sel;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] din_mux;

  assign hs_sel   = (state_q == GRANT) || (state_q == DRAIN);
  assign addr_mux = hs_sel ? bus.hs_address : bus.cpu_addr;
  assign din_mux  = hs_sel ? bus.hs_data_in : bus.cpu_din;

  assign bus.ram_addr      = addr_mux;
  assign bus.ram_din       = din_mux;
  assign bus.ram_we        = (state_q == GRANT) ? bus.hs_write_enable
                                                : (hs_sel ? 1'b0 : bus.cpu_we);
  assign bus.cpu_dout      = bus.ram_dout;
  assign bus.hs_data_out   = bus.ram_dout;
  assign bus.hs_grant      = grant_q;
  assign bus.cpu_pause_req = pause_q;
`ifdef HS_ARB_TIMEOUT_EN
  assign bus.timeout_err   = terr_q;
`else
  assign bus.timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a behavioural ownership/memory model.
module tb_hs_ram_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int BKO = 8;
`ifdef HS_ARB_TIMEOUT_EN
  localparam bit TO_EN   = 1'b1;
  localparam int ACK_DLY = 10;
`else
  localparam bit TO_EN   = 1'b0;
  localparam int ACK_DLY = 40;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hs_ram_arbiter_if #(.AW(AW), .DW(DW)) bus();

  hs_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .BACKOFF(BKO)) dut (
    .clk_49m (clk),
    .reset   (rst),
    .bus     (bus)
  );

  // Work RAM: synchronous, 1-cycle read latency, read-before-write.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: who owns the RAM and how long each phase has lasted.
  int  m_wait  = -1;   // cycles spent waiting for the pause ack, -1 when not waiting
  bit  m_grant = 1'b0;
  bit  m_drain = 1'b0;
  int  m_back  = 0;    // backoff cycles still to run
  bit  m_terr  = 1'b0;
  logic [DW-1:0] exp_mem [int];
  logic [DW-1:0] exp_rd;
  bit            exp_rd_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_mux(output logic [AW-1:0] a, output logic [DW-1:0] d, output logic w);
    bit hs_owns;
    hs_owns = m_grant || m_drain;
    a = hs_owns ? bus.hs_address : bus.cpu_addr;
    d = hs_owns ? bus.hs_data_in : bus.cpu_din;
    w = m_grant ? bus.hs_write_enable : (m_drain ? 1'b0 : bus.cpu_we);
  endtask

  task automatic model_step();
    bit terr;
    terr = 1'b0;
    if (rst) begin
      m_wait = -1; m_grant = 1'b0; m_drain = 1'b0; m_back = 0;
    end else if (m_grant) begin
      if (!bus.hs_access_req) begin m_grant = 1'b0; m_drain = 1'b1; end
    end else if (m_drain) begin
      m_drain = 1'b0;
    end else if (m_back > 0) begin
      m_back--;
    end else if (m_wait >= 0) begin
      if (!bus.hs_access_req)                 m_wait = -1;
      else if (bus.cpu_paused)                begin m_wait = -1; m_grant = 1'b1; end
      else if (TO_EN && m_wait == TMO - 1)    begin m_wait = -1; m_back = BKO; terr = 1'b1; end
      else                                    m_wait++;
    end else if (bus.hs_access_req) begin
      m_wait = 0;
    end
    m_terr = terr;
  endtask

  task automatic check_model();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    exp_mux(a, d, w);
    chk("model_grant",   32'(bus.hs_grant),      32'(m_grant));
    chk("model_pause",   32'(bus.cpu_pause_req), 32'((m_wait >= 0) || m_grant || m_drain));
    chk("model_terr",    32'(bus.timeout_err),   32'(m_terr));
    chk("model_ram_we",  32'(bus.ram_we),        32'(w));
    chk("model_ram_adr", 32'(bus.ram_addr),      32'(a));
    chk("model_ram_din", 32'(bus.ram_din),       32'(d));
    if (exp_rd_known) begin
      chk("model_cpu_dout", 32'(bus.cpu_dout),    32'(exp_rd));
      chk("model_hs_dout",  32'(bus.hs_data_out), 32'(exp_rd));
    end
  endtask

  // One clock: RAM/model advance on the rising edge, outputs checked on the falling edge.
  task automatic tick();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    @(posedge clk);
    exp_mux(a, d, w);
    exp_rd_known = exp_mem.exists(int'(a));
    if (exp_rd_known) exp_rd = exp_mem[int'(a)];
    if (w) exp_mem[int'(a)] = d;
    model_step();
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit rst, req, paused, hw, cw;
    bit e_pause, e_grant, e_we, e_sel;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    //           rst req  p  hw cw | pause grant we sel
    tbl[0]  = '{1, 0, 1, 0, 0,  0, 0, 0, 0};  // reset state
    tbl[1]  = '{0, 0, 1, 0, 1,  0, 0, 1, 0};  // CPU write passes in IDLE
    tbl[2]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0};  // request seen -> pause
    tbl[3]  = '{0, 1, 1, 1, 1,  1, 1, 1, 1};  // grant, hiscore writes 0x5A, CPU masked
    tbl[4]  = '{0, 1, 0, 1, 1,  1, 1, 1, 1};  // pause ack drops: grant holds
    tbl[5]  = '{0, 0, 1, 1, 1,  1, 0, 0, 1};  // release -> DRAIN, no write
    tbl[6]  = '{0, 1, 1, 1, 0,  0, 0, 0, 0};  // reassert in DRAIN ignored, IDLE
    tbl[7]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0};  // seen in IDLE -> pause again
    tbl[8]  = '{0, 1, 1, 0, 1,  1, 1, 0, 1};  // grant, CPU write masked
    tbl[9]  = '{1, 1, 1, 0, 0,  0, 0, 0, 0};  // reset mid-grant
    tbl[10] = '{0, 0, 1, 0, 0,  0, 0, 0, 0};  // no re-request while req low
    tbl[11] = '{0, 1, 1, 0, 0,  1, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 0,  1, 1, 0, 1};
    tbl[13] = '{0, 0, 1, 0, 0,  1, 0, 0, 1};
    tbl[14] = '{0, 0, 1, 0, 1,  0, 0, 1, 0};  // CPU writes enabled again

    rst = 1'b1;
    bus.hs_access_req   = 1'b0;
    bus.hs_address      = AW'(12'h123);
    bus.hs_data_in      = 8'h5A;
    bus.hs_write_enable = 1'b0;
    bus.cpu_addr        = AW'(12'h200);
    bus.cpu_din         = 8'hFF;
    bus.cpu_we          = 1'b0;
    bus.cpu_paused      = 1'b1;

    foreach (tbl[i]) begin
      rst                 = tbl[i].rst;
      bus.hs_access_req   = tbl[i].req;
      bus.cpu_paused      = tbl[i].paused;
      bus.hs_write_enable = tbl[i].hw;
      bus.cpu_we          = tbl[i].cw;
      tick();
      chk($sformatf("tbl%0d_pause", i), 32'(bus.cpu_pause_req), 32'(tbl[i].e_pause));
      chk($sformatf("tbl%0d_grant", i), 32'(bus.hs_grant),      32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_we", i),    32'(bus.ram_we),        32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_addr", i),  32'(bus.ram_addr),
          tbl[i].e_sel ? 32'h123 : 32'h200);
      chk($sformatf("tbl%0d_terr", i),  32'(bus.timeout_err),   32'd0);
    end

    // CPU reads back what the hiscore side wrote.
    bus.cpu_we = 1'b0; bus.cpu_addr = AW'(12'h123);
    tick(); tick();
    chk("readback_5a", 32'(bus.cpu_dout), 32'h5A);

    // Masking: both sides write 0x123 during GRANT; only the hiscore value may land.
    bus.hs_data_in = 8'h11; bus.cpu_din = 8'hFF; bus.cpu_paused = 1'b1;
    bus.hs_access_req = 1'b1;
    tick(); tick();
    bus.hs_write_enable = 1'b1; bus.cpu_we = 1'b1;
    #1;
    chk("mask_grant_we",  32'(bus.ram_we),  32'd1);
    chk("mask_grant_din", 32'(bus.ram_din), 32'h11);
    tick();
    bus.hs_access_req = 1'b0;
    tick();
    chk("mask_drain_we", 32'(bus.ram_we), 32'd0);
    bus.hs_write_enable = 1'b0; bus.cpu_we = 1'b0;
    tick(); tick();
    chk("mask_readback", 32'(bus.cpu_dout), 32'h11);
    chk("mask_idle_pause", 32'(bus.cpu_pause_req), 32'd0);

    // Delayed ack with hiscore write strobe asserted early.
    bus.cpu_paused = 1'b0; bus.hs_write_enable = 1'b1; bus.hs_access_req = 1'b1;
    for (int k = 0; k < ACK_DLY; k++) begin
      tick();
      chk("dly_no_grant", 32'(bus.hs_grant), 32'd0);
      chk("dly_no_we",    32'(bus.ram_we),   32'd0);
    end
    bus.cpu_paused = 1'b1;
    tick();
    chk("dly_grant_next", 32'(bus.hs_grant), 32'd1);
    bus.hs_access_req = 1'b0; bus.hs_write_enable = 1'b0;
    tick(); tick(); tick();

`ifdef HS_ARB_TIMEOUT_EN
    // Timeout with the CPU never acknowledging.
    bus.cpu_paused = 1'b0; bus.hs_access_req = 1'b1;
    tick();
    t0 = cyc;
    chk("to_pause_rise", 32'(bus.cpu_pause_req), 32'd1);
    while (!bus.timeout_err && (cyc - t0) < 100) tick();
    t1 = cyc;
    chk("to_err_seen",    32'(bus.timeout_err),   32'd1);
    chk("to_err_delay",   32'(t1 - t0),           32'(TMO));
    chk("to_pause_fall",  32'(bus.cpu_pause_req), 32'd0);
    tick();
    chk("to_err_single",  32'(bus.timeout_err),   32'd0);
    while (!bus.cpu_pause_req && (cyc - t1) < 100) tick();
    t2 = cyc;
    chk("to_rerequest",   32'(bus.cpu_pause_req), 32'd1);
    chk("to_backoff_len", 32'(t2 - t1),           32'(BKO + 1));
    bus.hs_access_req = 1'b0;
    tick(); tick();
`endif

    // Random traffic on a handful of addresses so reads hit earlier writes.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.hs_access_req = ~bus.hs_access_req;
      if ($urandom_range(0, 5) == 0) bus.cpu_paused    = ~bus.cpu_paused;
      bus.hs_write_enable = 1'($urandom_range(0, 1));
      bus.cpu_we          = 1'($urandom_range(0, 1));
      bus.hs_address      = AW'($urandom_range(0, 7));
      bus.cpu_addr        = AW'($urandom_range(0, 7));
      bus.hs_data_in      = DW'($urandom);
      bus.cpu_din         = DW'($urandom);
      rst                 = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hs_ram_arbiter.md
# hs_ram_arbiter

Shares the single-port game work RAM between the game CPU and the hiscore save/restore engine. When the hiscore engine asks for access, the arbiter requests a CPU pause and waits for the pause acknowledge. It then switches the RAM address, data and write-enable mux to the hiscore side, and hands the RAM back after a drain cycle. It sits between the game core's work-RAM port, the pause system and the hiscore module, replacing the ad-hoc dual-porting of hiscore RAM.

## Interface
Parameters:
- AW, 12, RAM address width
- DW, 8, RAM data width
- TIMEOUT, 4096, cycles to wait for `cpu_paused` before abandoning a request
- BACKOFF, 256, cycles the CPU owns RAM after a timeout before a new request is accepted

Ports:
- clk_49m  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- hs_access_req  in  1  hiscore engine wants RAM; held until done
- hs_address  in  AW  hiscore RAM address
- hs_data_in  in  DW  hiscore write data
- hs_write_enable  in  1  hiscore write strobe; honoured only while granted
- hs_data_out  out  DW  RAM read data to hiscore
- hs_grant  out  1  hiscore owns RAM
- cpu_addr  in  AW  CPU RAM address
- cpu_din  in  DW  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_dout  out  DW  RAM read data to CPU
- cpu_pause_req  out  1  request to the pause system
- cpu_paused  in  1  CPU is halted
- ram_addr  out  AW  to RAM
- ram_din  out  DW  to RAM
- ram_we  out  1  to RAM
- ram_dout  in  DW  from RAM; synchronous, 1-cycle read latency
- timeout_err  out  1  one-cycle pulse when a pause request times out

## Operation
FSM states and transitions:
- IDLE: mux selects CPU. `hs_access_req`=1 moves to PAUSE_REQ.
- PAUSE_REQ: `cpu_pause_req`=1 and the timeout counter increments from 0.
  - `cpu_paused`=1 moves to GRANT.
  - Counter reaching TIMEOUT-1 with no ack moves to BACKOFF and pulses `timeout_err`.
  - `hs_access_req` dropping moves to IDLE.
- GRANT: `hs_grant`=1, `cpu_pause_req`=1, mux selects hiscore, `ram_we`=`hs_write_enable`. `hs_access_req`=0 moves to DRAIN.
- DRAIN: one cycle. Mux stays on hiscore with `ram_we` forced 0 and `cpu_pause_req` still 1, so the last hiscore write lands before the CPU resumes. Then IDLE.
- BACKOFF: mux selects CPU, `cpu_pause_req`=0, `hs_access_req` ignored. The counter counts BACKOFF cycles, then the FSM returns to IDLE.

Mux and data rules:
- `ram_addr`, `ram_din` and `ram_we` are combinational muxes on the registered state.
- `cpu_we` is masked to 0 in GRANT and DRAIN.
- `hs_write_enable` is masked to 0 outside GRANT.
- `cpu_dout` and `hs_data_out` both wire directly to `ram_dout`. Each side consumes the data only when it owns the RAM.
- `cpu_paused` falling during GRANT is ignored: the grant holds and CPU writes stay masked.
- Only one counter exists; it is shared between PAUSE_REQ and BACKOFF, width $clog2(max(TIMEOUT,BACKOFF)+1), and is cleared on every state entry.

## Timing
- Reset value of every registered output is 0: `hs_grant`, `cpu_pause_req`, `timeout_err`, the state (IDLE) and the counter.
- Reset in any state returns to IDLE on the next edge and releases the pause immediately. A hiscore write in flight is dropped.
- `hs_access_req` sampled at edge N gives `cpu_pause_req`=1 from N+1.
- `cpu_paused` sampled at edge M gives `hs_grant`=1 from M+1.
  - Minimum request-to-grant latency is 2 cycles, which occurs when `cpu_paused` is already high.
- Hiscore reads: address presented in cycle k (granted) gives data on `hs_data_out` in cycle k+1. The hiscore side holds the request through its last read.
- Release: `hs_access_req`=0 sampled at edge R gives DRAIN in cycle R+1, IDLE with `cpu_pause_req`=0 in R+2, and CPU writes enabled from R+2.
- `hs_access_req` reasserted in DRAIN is ignored. It is seen in IDLE, so back-to-back grants are 3 cycles apart minimum.
- Timeout: `timeout_err` is high for exactly the first BACKOFF cycle.

## Configuration
- `HS_ARB_TIMEOUT_EN` defined: the PAUSE_REQ timeout, the BACKOFF state and `timeout_err` are compiled in.
- `HS_ARB_TIMEOUT_EN` undefined: PAUSE_REQ waits indefinitely for `cpu_paused`, BACKOFF is unreachable, `timeout_err` is tied to 0, and the counter is removed.

## Test plan
- Basic grant: `cpu_paused` tied 1, raise `hs_access_req` at cycle 10.
  - `cpu_pause_req`=1 at cycle 11 and `hs_grant`=1 at 12.
  - Write 0x5A to 0x123 in GRANT, release, then a CPU read of 0x123 returns 0x5A.
- Delayed ack: `cpu_paused` rises 40 cycles after the request. `hs_grant` rises exactly 1 cycle later, and `ram_we` stays 0 despite `hs_write_enable`=1 before the grant.
- Masking: during GRANT, the CPU writes 0xFF to 0x123 while the hiscore writes 0x11. RAM holds 0x11, and `cpu_we` never reaches `ram_we` in GRANT or DRAIN.
- Drain and back-to-back: drop `hs_access_req` at edge R and reassert it at R+1.
  - DRAIN occurs at R+1 with `ram_we`=0.
  - IDLE at R+2 with `cpu_pause_req`=0, then `cpu_pause_req`=1 again at R+3.
- Timeout (with `HS_ARB_TIMEOUT_EN`, TIMEOUT=16, BACKOFF=8, `cpu_paused`=0):
  - `timeout_err` pulses once 16 cycles after `cpu_pause_req` rises.
  - `cpu_pause_req` falls the same cycle, and the request is re-accepted 8 cycles later.
- Reset mid-GRANT: assert `reset` for 1 cycle. Next cycle `hs_grant`=0, `cpu_pause_req`=0 and the mux is on the CPU, and the FSM re-requests only after `hs_access_req` is seen in IDLE.
